// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the RV32 instruction fetch
//               stage: fetch state encoding, PC increment, default reset PC.
//               The HALT state exists only when FETCH_MISALIGN_TRAP_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

`ifdef FETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_ISSUE = 3'd3
   } fetch_state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
// Module      : next_pc_sel
// Description : Purely combinational next-PC selection for the fetch stage.
//               Priority: JALR target (bit 0 cleared), JAL target, taken BEQ
//               target, sequential PC + 4. All arithmetic wraps mod 2^32.
// Ports       : instr_pc    - PC of the retiring instruction
//               imm         - sign-extended immediate
//               alu_out     - ALU result (JALR target rs1 + imm)
//               branch_*    - control unit branch flags
//               alu_compare - srcA == srcB
//               next_pc     - selected next fetch address
//               misaligned  - next_pc[1:0] != 0 (FETCH_MISALIGN_TRAP_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module next_pc_sel
   import fetch_pkg::*;
(
   input  logic [31:0] instr_pc,
   input  logic [31:0] imm,
   input  logic [31:0] alu_out,
   input  logic        branch_beq,
   input  logic        branch_jal,
   input  logic        branch_jalr,
   input  logic        alu_compare,
   output logic [31:0] next_pc
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misaligned
`endif
);

   logic [31:0] w_branch_target;
   logic [31:0] w_seq_pc;
   logic        w_unused_alu_lsb;

   assign w_branch_target  = instr_pc + imm;
   assign w_seq_pc         = instr_pc + PC_STEP;
   // JALR architecturally discards bit 0 of the computed target.
   assign w_unused_alu_lsb = alu_out[0];

   always_comb begin
      next_pc = w_seq_pc;
      if (branch_jalr) begin
         next_pc = {alu_out[31:1], 1'b0};
      end else if (branch_jal) begin
         next_pc = w_branch_target;
      end else if (branch_beq && alu_compare) begin
         next_pc = w_branch_target;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   assign misaligned = |next_pc[1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction fetch stage of the single-cycle RV32 core. Holds
//               the PC, fetches one instruction at a time over a
//               req/gnt/rvalid handshake, presents it to decode and selects
//               the next PC when execute retires it. One instruction in
//               flight at any time.
// Config      : FETCH_MISALIGN_TRAP_EN - when defined, a retire whose next PC
//               is not word aligned updates the PC, raises the sticky
//               misalign output and parks the unit in HALT until reset.
// Ports       : clk, rst_n              - clock, async active-low reset
//               imem_req/imem_addr      - registered fetch request/address
//               imem_gnt/imem_rvalid/imem_rdata - memory handshake/response
//               instr/instr_pc/pc_plus4/instr_valid - to decode
//               instr_ready             - execute retires instr
//               branch_beq/jal/jalr, alu_compare, imm, alu_out - next PC
//               misalign                - sticky trap flag (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
)(
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   input  logic        branch_beq,
   input  logic        branch_jal,
   input  logic        branch_jalr,
   input  logic        alu_compare,
   input  logic [31:0] imm,
   input  logic [31:0] alu_out
`ifdef FETCH_MISALIGN_TRAP_EN
   ,
   output logic        misalign
`endif
);

   fetch_state_t r_state;
   fetch_state_t w_state_nxt;
   logic [31:0]  r_pc;
   logic [31:0]  r_instr;
   logic         r_req;
   logic         r_valid;
   logic         w_capture;
   logic         w_retire;
   logic [31:0]  w_next_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic         w_misaligned;
   logic         r_misalign;
`endif

   next_pc_sel u_next_pc_sel (
      .instr_pc    (r_pc),
      .imm         (imm),
      .alu_out     (alu_out),
      .branch_beq  (branch_beq),
      .branch_jal  (branch_jal),
      .branch_jalr (branch_jalr),
      .alu_compare (alu_compare),
      .next_pc     (w_next_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misaligned  (w_misaligned)
`endif
   );

   // Retire only counts while an instruction is actually presented.
   assign w_retire = (r_state == ST_ISSUE) && instr_ready;

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            // A response without a grant belongs to a request cut off by
            // reset and must not be taken as ours.
            if (imem_gnt) begin
               if (imem_rvalid) begin
                  w_capture   = 1'b1;
                  w_state_nxt = ST_ISSUE;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (imem_rvalid) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (instr_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
               w_state_nxt = w_misaligned ? ST_HALT : ST_FETCH;
`else
               w_state_nxt = ST_FETCH;
`endif
            end
         end
`ifdef FETCH_MISALIGN_TRAP_EN
         ST_HALT: begin
            w_state_nxt = ST_HALT;
         end
`endif
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_pc    <= RESET_PC;
         r_instr <= 32'h0;
         r_req   <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         // Request/valid are flops decoded from the next state so that no
         // input has a combinational path to these outputs.
         r_req   <= (w_state_nxt == ST_FETCH);
         r_valid <= (w_state_nxt == ST_ISSUE);
         if (w_capture) begin
            r_instr <= imem_rdata;
         end
         if (w_retire) begin
            r_pc <= w_next_pc;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_misalign <= 1'b0;
      end else if (w_retire && w_misaligned) begin
         r_misalign <= 1'b1;
      end
   end

   assign misalign = r_misalign;
`endif

   // The PC only moves on retire, so the fetch address and the PC of the
   // presented instruction are the same register.
   assign imem_req    = r_req;
   assign imem_addr   = r_pc;
   assign instr       = r_instr;
   assign instr_pc    = r_pc;
   assign pc_plus4    = r_pc + PC_STEP;
   assign instr_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit (RESET_PC = 0x100). A
//               memory/execute driver runs one instruction at a time with
//               configurable grant delay, response latency and retire stall;
//               expected fetch addresses and instruction words are queued as
//               stimulus is driven and compared when the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

   localparam logic [31:0] C_RST_PC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic [31:0] pc_plus4;
   logic        instr_valid;
   logic        instr_ready;
   logic        branch_beq;
   logic        branch_jal;
   logic        branch_jalr;
   logic        alu_compare;
   logic [31:0] imm;
   logic [31:0] alu_out;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign;
`endif

   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          last_req_cyc = 0;
   int          prev_cost    = 0;
   bit          has_prev     = 1'b0;
   logic [31:0] model_pc;
   logic [31:0] exp_addr_q[$];
   logic [31:0] exp_instr_q[$];

   fetch_unit #(
      .RESET_PC (C_RST_PC)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .branch_beq  (branch_beq),
      .branch_jal  (branch_jal),
      .branch_jalr (branch_jalr),
      .alu_compare (alu_compare),
      .imm         (imm),
      .alu_out     (alu_out)
`ifdef FETCH_MISALIGN_TRAP_EN
      ,
      .misalign    (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #300000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] pc, input logic beq,
                                              input logic jal, input logic jalr, input logic cmp,
                                              input logic [31:0] imm_v, input logic [31:0] alu_v);
      if (jalr) return {alu_v[31:1], 1'b0};
      if (jal) return pc + imm_v;
      if (beq && cmp) return pc + imm_v;
      return pc + 32'd4;
   endfunction

   task automatic drive_idle();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      branch_beq  = 1'b0;
      branch_jal  = 1'b0;
      branch_jalr = 1'b0;
      alu_compare = 1'b0;
      imm         = 32'h0;
      alu_out     = 32'h0;
   endtask

   task automatic restart_model();
      exp_addr_q.delete();
      exp_instr_q.delete();
      model_pc = C_RST_PC;
      has_prev = 1'b0;
   endtask

   task automatic apply_reset();
      drive_idle();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 32'h0);
      check("rst_addr", imem_addr, C_RST_PC);
      check("rst_instr", instr, 32'h0);
      check("rst_instr_pc", instr_pc, C_RST_PC);
      check("rst_pc_plus4", pc_plus4, C_RST_PC + 32'd4);
      check("rst_valid", instr_valid, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      check("rst_misalign", misalign, 32'h0);
`endif
      rst_n = 1'b1;
      restart_model();
   endtask

   task automatic wait_req();
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_seen", imem_req, 32'h1);
   endtask

   // One instruction: grant after gdly FETCH cycles, response rdly cycles
   // after grant (0 = same cycle), retire after stall cycles.
   task automatic do_instr(input int gdly, input int rdly, input int stall,
                           input logic beq, input logic jal, input logic jalr,
                           input logic cmp, input logic [31:0] imm_v,
                           input logic [31:0] alu_v);
      logic [31:0] word;
      exp_addr_q.push_back(model_pc);
      wait_req();
      if (has_prev) check("instr_period", cyc - last_req_cyc, prev_cost);
      last_req_cyc = cyc;
      check("fetch_addr", imem_addr, exp_addr_q.pop_front());
      for (int g = 0; g < gdly; g++) begin
         imem_rvalid = 1'b1;
         imem_rdata  = 32'hDEAD_0000 | g;
         @(negedge clk);
         check("req_hold", imem_req, 32'h1);
         check("addr_hold", imem_addr, model_pc);
      end
      word = $urandom;
      exp_instr_q.push_back(word);
      imem_gnt    = 1'b1;
      imem_rvalid = (rdly == 0);
      imem_rdata  = (rdly == 0) ? word : 32'hDEAD_BEEF;
      @(negedge clk);
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      if (rdly > 0) begin
         for (int i = 1; i < rdly; i++) begin
            check("wait_noreq", imem_req, 32'h0);
            check("wait_novalid", instr_valid, 32'h0);
            @(negedge clk);
         end
         check("wait_noreq", imem_req, 32'h0);
         imem_rvalid = 1'b1;
         imem_rdata  = word;
         @(negedge clk);
         imem_rvalid = 1'b0;
      end
      check("valid", instr_valid, 32'h1);
      check("issue_noreq", imem_req, 32'h0);
      check("instr", instr, exp_instr_q.pop_front());
      check("instr_pc", instr_pc, model_pc);
      check("pc_plus4", pc_plus4, model_pc + 32'd4);
      for (int s = 0; s < stall; s++) begin
         imem_rvalid = 1'b1;
         imem_rdata  = ~word;
         @(negedge clk);
         imem_rvalid = 1'b0;
         check("stall_instr", instr, word);
         check("stall_valid", instr_valid, 32'h1);
         check("stall_noreq", imem_req, 32'h0);
      end
      instr_ready = 1'b1;
      branch_beq  = beq;
      branch_jal  = jal;
      branch_jalr = jalr;
      alu_compare = cmp;
      imm         = imm_v;
      alu_out     = alu_v;
      @(negedge clk);
      drive_idle();
      model_pc = model_next(model_pc, beq, jal, jalr, cmp, imm_v, alu_v);
      check("retire_valid_drop", instr_valid, 32'h0);
      prev_cost = 2 + gdly + rdly + stall;
      has_prev  = 1'b1;
   endtask

   initial begin
      drive_idle();
      rst_n    = 1'b0;
      model_pc = C_RST_PC;
      apply_reset();

      // Back-to-back best case: 0x100, 0x104, 0x108, two cycles each.
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      // Slow memory and slow execute, stale rvalid before grant.
      do_instr(1, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset while waiting for the response, then a late response.
      wait_req();
      check("pre_rst_addr", imem_addr, model_pc);
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      check("wait_state_noreq", imem_req, 32'h0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_instr", instr, 32'h0);
      check("async_rst_addr", imem_addr, C_RST_PC);
      check("async_rst_pc_plus4", pc_plus4, C_RST_PC + 32'd4);
      @(negedge clk);
      rst_n       = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_BAD0;
      @(negedge clk);
      @(negedge clk);
      imem_rvalid = 1'b0;
      check("late_rvalid_ignored", instr, 32'h0);
      check("late_rvalid_novalid", instr_valid, 32'h0);
      restart_model();

      // JALR beats JAL; bit 0 of target cleared: 0x100 -> 0x300 -> 0x200.
      do_instr(0, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0000_0301);
      do_instr(0, 1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0201);
      // Taken BEQ backwards, not-taken BEQ, JAL, not-taken at 0x200.
      do_instr(0, 0, 1, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 32'h0);
      do_instr(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      do_instr(2, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h4, 32'h0);
      do_instr(0, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFF8, 32'h0);
      // Jump to the top of memory and wrap to zero.
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      // JAL to a misaligned target from 0x0.
      do_instr(0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h6, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
      for (int i = 0; i < 4; i++) begin
         check("halt_misalign", misalign, 32'h1);
         check("halt_noreq", imem_req, 32'h0);
         check("halt_novalid", instr_valid, 32'h0);
         @(negedge clk);
      end
      check("halt_pc", imem_addr, 32'h0000_0006);
      apply_reset();
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`else
      do_instr(0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
